// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Decode register plus a FWD_DEPTH-deep destination tracking pipeline.
//   Produces operand forwarding selects, EX/DM memory controls, a one-cycle
//   load-use stall and a post-jump squash window for the fetch stream.
module hazard_fwd_unit #(
   parameter  int FWD_DEPTH    = 3,
   parameter  int JMP_BUBBLES  = 1,
   parameter  int R0_HARDWIRED = 1,
   localparam int SEL_W        = $clog2(FWD_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ins_valid,
   input  logic [31:0]      ins,
   output logic             stall,
   output logic             flush,
   output logic [SEL_W-1:0] fwd_sel_a,
   output logic [SEL_W-1:0] fwd_sel_b,
   output logic [5:0]       op_dec,
   output logic [15:0]      imm,
   output logic             imm_sel,
   output logic             mem_en_ex,
   output logic             mem_rw_ex,
   output logic             mem_mux_sel_dm,
   output logic [4:0]       rw_dm,
   output logic             rw_dm_valid
);

   localparam logic [5:0] OP_LD  = 6'b010100;
   localparam logic [5:0] OP_ST  = 6'b010101;
   localparam logic [5:0] OP_JMP = 6'b011000;

   // RUN: normal flow, STALL: load-use freeze, SQUASH: post-jump kill window
   typedef enum logic [1:0] {M_RUN, M_STALL, M_SQUASH} mode_t;

   function automatic logic is_jump(input logic [5:0] op);
      return (op == OP_JMP) || (op[5:2] == 4'b0111);
   endfunction

   function automatic logic writes_rw(input logic [5:0] op);
      return !((op == OP_ST) || is_jump(op));
   endfunction

   // vld_pipe[0] is the decode slot, vld_pipe[k] tracked stage k
   logic [FWD_DEPTH:0]      vld_pipe;
   logic [31:0]             d_ins;
   logic [FWD_DEPTH:1]      stg_wr;
   logic [FWD_DEPTH:1][4:0] stg_rw;
   logic [5:0]              ex_op;
   logic [5:0]              dm_op;
   logic [1:0]              squash_cnt;
   logic [1:0]              squash_nxt;
   mode_t                   mode;

   logic [5:0]              d_op;
   logic [4:0]              d_rw;
   logic [4:0]              d_ra;
   logic [4:0]              d_rb;
   logic [FWD_DEPTH:1]      hit_a;
   logic [FWD_DEPTH:1]      hit_b;
   logic                    ld_use;
   logic [SEL_W-1:0]        sel_a;
   logic [SEL_W-1:0]        sel_b;

   assign d_op = d_ins[31:26];
   assign d_rw = d_ins[25:21];
   assign d_ra = d_ins[20:16];
   assign d_rb = d_ins[15:11];

   // Per-stage comparators: a stage only forwards a real, non-r0 write
   for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_match
      logic live;
      assign live     = vld_pipe[k] & stg_wr[k] &
                        ~((R0_HARDWIRED != 0) && (stg_rw[k] == 5'd0));
      assign hit_a[k] = live & (stg_rw[k] == d_ra);
      assign hit_b[k] = live & (stg_rw[k] == d_rb);
   end

   // Youngest matching stage wins: scan oldest to youngest, last hit sticks
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         if (vld_pipe[0] && hit_a[k]) sel_a = SEL_W'(k);
         if (vld_pipe[0] && hit_b[k]) sel_b = SEL_W'(k);
      end
   end

   // Load in EX feeding the decode operands cannot be forwarded yet
   always_comb begin
      ld_use = vld_pipe[0] & vld_pipe[1] & (ex_op == OP_LD) &
               (hit_a[1] | hit_b[1]);
      if (ld_use)                mode = M_STALL;
      else if (squash_cnt != '0) mode = M_SQUASH;
      else                       mode = M_RUN;
   end

   // Squash counter state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) squash_cnt <= '0;
      else       squash_cnt <= squash_nxt;
   end

   // Squash next-state: a jump leaving decode reloads, stall freezes,
   // and only real fetched slots count down the window
   always_comb begin
      squash_nxt = squash_cnt;
      if (mode != M_STALL) begin
         if (vld_pipe[0] && is_jump(d_op))
            squash_nxt = 2'(JMP_BUBBLES);
         else if ((mode == M_SQUASH) && ins_valid)
            squash_nxt = squash_cnt - 2'd1;
      end
   end

   // Decode register: hold on stall, bubble while squashing or idle fetch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe[0] <= 1'b0;
         d_ins       <= '0;
      end else if (mode != M_STALL) begin
         if ((mode == M_SQUASH) || !ins_valid) begin
            vld_pipe[0] <= 1'b0;
            d_ins       <= '0;
         end else begin
            vld_pipe[0] <= 1'b1;
            d_ins       <= ins;
         end
      end
   end

   // Stage 1 takes decode, or a bubble while decode is frozen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe[1] <= 1'b0;
         stg_wr[1]   <= 1'b0;
         stg_rw[1]   <= '0;
         ex_op       <= '0;
      end else if (mode == M_STALL) begin
         vld_pipe[1] <= 1'b0;
         stg_wr[1]   <= 1'b0;
         stg_rw[1]   <= '0;
         ex_op       <= '0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         stg_wr[1]   <= vld_pipe[0] & writes_rw(d_op);
         stg_rw[1]   <= d_rw;
         ex_op       <= d_op;
      end
   end

   // Older stages always advance so a stalled load still reaches DM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe[FWD_DEPTH:2] <= '0;
         stg_wr[FWD_DEPTH:2]   <= '0;
         stg_rw[FWD_DEPTH:2]   <= '0;
         dm_op                 <= '0;
      end else begin
         for (int k = 2; k <= FWD_DEPTH; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            stg_wr[k]   <= stg_wr[k-1];
            stg_rw[k]   <= stg_rw[k-1];
         end
         dm_op <= ex_op;
      end
   end

   // Output decode: decode-slot fields, EX memory controls, DM writeback info
   always_comb begin
      stall          = (mode == M_STALL);
      flush          = (mode == M_SQUASH) & ins_valid;
      fwd_sel_a      = sel_a;
      fwd_sel_b      = sel_b;
      op_dec         = vld_pipe[0] ? d_op : 6'd0;
      imm            = vld_pipe[0] ? d_ins[15:0] : 16'd0;
      imm_sel        = vld_pipe[0] & (d_op[5:3] == 3'b001);
      mem_en_ex      = vld_pipe[1] & ((ex_op == OP_LD) | (ex_op == OP_ST));
      mem_rw_ex      = vld_pipe[1] & (ex_op == OP_ST);
      mem_mux_sel_dm = vld_pipe[2] & (dm_op == OP_LD);
      rw_dm          = vld_pipe[2] ? stg_rw[2] : 5'd0;
      rw_dm_valid    = vld_pipe[2] & stg_wr[2];
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: two instances (FWD_DEPTH 3 and 5) share one
// stimulus stream and are compared against a list-based reference model.
module tb_hazard_fwd_unit;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b001010;
   localparam logic [5:0] OP_LD   = 6'b010100;
   localparam logic [5:0] OP_ST   = 6'b010101;
   localparam logic [5:0] OP_JMP  = 6'b011000;
   localparam logic [5:0] OP_JC   = 6'b011110;
   localparam int         JB      = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ins_valid = 1'b0;
   logic [31:0] ins = '0;

   logic       st0, fl0, isel0, me0, mrw0, mmx0, rwv0;
   logic [1:0] sa0, sb0;
   logic [5:0] opd0;
   logic [15:0] imm0;
   logic [4:0] rwd0;
   logic       st1, fl1, isel1, me1, mrw1, mmx1, rwv1;
   logic [2:0] sa1, sb1;
   logic [5:0] opd1;
   logic [15:0] imm1;
   logic [4:0] rwd1;

   hazard_fwd_unit #(.FWD_DEPTH(3), .JMP_BUBBLES(JB), .R0_HARDWIRED(1)) u0 (
      .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins(ins),
      .stall(st0), .flush(fl0), .fwd_sel_a(sa0), .fwd_sel_b(sb0),
      .op_dec(opd0), .imm(imm0), .imm_sel(isel0), .mem_en_ex(me0),
      .mem_rw_ex(mrw0), .mem_mux_sel_dm(mmx0), .rw_dm(rwd0), .rw_dm_valid(rwv0));

   hazard_fwd_unit #(.FWD_DEPTH(5), .JMP_BUBBLES(JB), .R0_HARDWIRED(1)) u1 (
      .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins(ins),
      .stall(st1), .flush(fl1), .fwd_sel_a(sa1), .fwd_sel_b(sb1),
      .op_dec(opd1), .imm(imm1), .imm_sel(isel1), .mem_en_ex(me1),
      .mem_rw_ex(mrw1), .mem_mux_sel_dm(mmx1), .rw_dm(rwd1), .rw_dm_valid(rwv1));

   always #5 clk = ~clk;

   // Reference model: decode slot plus a list of in-flight instructions
   typedef struct {
      bit       v;
      bit [5:0] op;
      bit [4:0] rw;
      bit       wr;
   } ent_t;

   ent_t        pipe [1:6];
   bit          dv;
   logic [31:0] dins;
   int          sq;
   bit          last_stall;
   logic        last_flush;
   int          n_vec = 0;
   int          n_err = 0;

   logic [5:0]  rop;
   logic [31:0] ri;
   bit          rv;

   function automatic bit is_jump(input logic [5:0] op);
      return (op == OP_JMP) || (op[5:2] == 4'b0111);
   endfunction

   function automatic bit writes_reg(input logic [5:0] op);
      return !((op == OP_ST) || is_jump(op));
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rw,
                                      input logic [4:0] ra, input logic [4:0] rb);
      return {op, rw, ra, rb, 11'd0};
   endfunction

   function automatic bit hit(input int k, input logic [4:0] r);
      return pipe[k].v && pipe[k].wr && (pipe[k].rw == r) && (r != 5'd0);
   endfunction

   function automatic int exp_sel(input int depth, input logic [4:0] r);
      if (!dv) return 0;
      for (int k = 1; k <= depth; k++)
         if (hit(k, r)) return k;
      return 0;
   endfunction

   function automatic bit exp_stall();
      return dv && pipe[1].v && (pipe[1].op == OP_LD) &&
             (hit(1, dins[20:16]) || hit(1, dins[15:11]));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 1; k <= 6; k++) pipe[k] = '{1'b0, 6'd0, 5'd0, 1'b0};
      dv = 1'b0;
      dins = '0;
      sq = 0;
      last_stall = 1'b0;
   endtask

   // Advance the model by one clock edge using the rules of the unit
   task automatic model_edge(input bit v, input logic [31:0] i);
      bit   st;
      int   sq_old;
      ent_t e;
      st = exp_stall();
      sq_old = sq;
      e = '{1'b0, 6'd0, 5'd0, 1'b0};
      if (!st && dv) e = '{1'b1, dins[31:26], dins[25:21], writes_reg(dins[31:26])};
      for (int k = 6; k >= 2; k--) pipe[k] = pipe[k-1];
      pipe[1] = e;
      if (!st) begin
         if (dv && is_jump(dins[31:26])) sq = JB;
         else if (sq > 0 && v) sq = sq - 1;
         if (sq_old == 0 && v) begin
            dv = 1'b1;
            dins = i;
         end else begin
            dv = 1'b0;
            dins = '0;
         end
      end
   endtask

   task automatic check_all(input bit v);
      bit       es, ef, me;
      bit [5:0] op;
      op = dins[31:26];
      es = exp_stall();
      ef = !es && (sq > 0) && v;
      me = pipe[1].v && ((pipe[1].op == OP_LD) || (pipe[1].op == OP_ST));
      last_stall = es;
      last_flush = fl0;
      chk("stall_d3", st0, es);
      chk("stall_d5", st1, es);
      chk("flush_d3", fl0, ef);
      chk("flush_d5", fl1, ef);
      chk("sel_a_d3", sa0, exp_sel(3, dins[20:16]));
      chk("sel_b_d3", sb0, exp_sel(3, dins[15:11]));
      chk("sel_a_d5", sa1, exp_sel(5, dins[20:16]));
      chk("sel_b_d5", sb1, exp_sel(5, dins[15:11]));
      chk("op_dec_d3", opd0, dv ? op : 6'd0);
      chk("op_dec_d5", opd1, dv ? op : 6'd0);
      if (dv) chk("imm_d3", imm0, dins[15:0]);
      chk("imm_sel_d3", isel0, dv && (op[5:3] == 3'b001));
      chk("mem_en_d3", me0, me);
      chk("mem_en_d5", me1, me);
      if (me) chk("mem_rw_d3", mrw0, pipe[1].op == OP_ST);
      chk("mem_mux_d3", mmx0, pipe[2].v && (pipe[2].op == OP_LD));
      chk("mem_mux_d5", mmx1, pipe[2].v && (pipe[2].op == OP_LD));
      if (pipe[2].v) chk("rw_dm_d3", rwd0, pipe[2].rw);
      chk("rw_dm_valid_d3", rwv0, pipe[2].v && pipe[2].wr);
      chk("rw_dm_valid_d5", rwv1, pipe[2].v && pipe[2].wr);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_stall"}, {st0, st1}, 0);
      chk({tag, "_flush"}, {fl0, fl1}, 0);
      chk({tag, "_sel"}, {sa0, sb0, sa1, sb1}, 0);
      chk({tag, "_op_dec"}, {opd0, opd1}, 0);
      chk({tag, "_imm"}, {imm0, imm1}, 0);
      chk({tag, "_ex"}, {isel0, me0, mrw0, isel1, me1, mrw1}, 0);
      chk({tag, "_dm"}, {mmx0, rwd0, rwv0, mmx1, rwd1, rwv1}, 0);
   endtask

   // One fetch cycle: drive, compare mid-cycle, then step the model at the edge
   task automatic step(input bit v, input logic [31:0] i);
      ins_valid = v;
      ins = i;
      @(negedge clk);
      check_all(v);
      @(posedge clk);
      model_edge(v, i);
      #1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("rst_hold");
      reset = 1'b0;
      #1;
      chk_zero("rst_release");

      // back-to-back RAW through stage 1
      step(1'b1, mk(OP_ADD, 5'd3, 5'd1, 5'd2));
      step(1'b1, mk(OP_SUB, 5'd4, 5'd3, 5'd3));
      chk("t1_sel_a", sa0, 1);
      chk("t1_sel_b", sb0, 1);
      chk("t1_stall", st0, 0);

      // load-use: one stall, one bubble, then forward from stage 2
      step(1'b1, mk(OP_LD, 5'd5, 5'd1, 5'd0));
      step(1'b1, mk(OP_ADD, 5'd6, 5'd5, 5'd1));
      chk("t2_stall", st0, 1);
      step(1'b1, mk(OP_ADD, 5'd6, 5'd5, 5'd1));
      chk("t2_stall_clear", st0, 0);
      chk("t2_sel_a", sa0, 2);
      chk("t2_mux_dm", mmx0, 1);
      chk("t2_bubble_ex", me0, 0);
      step(1'b1, mk(OP_ADD, 5'd12, 5'd1, 5'd1));

      // jump leaves decode during an idle fetch slot; next valid slot is killed
      step(1'b1, mk(OP_JMP, 5'd0, 5'd1, 5'd0));
      step(1'b0, 32'd0);
      step(1'b1, mk(OP_ADD, 5'd7, 5'd1, 5'd1));
      chk("t3_flush", last_flush, 1);
      chk("t3_dec_bubble", opd0, 0);
      step(1'b1, mk(OP_SUB, 5'd8, 5'd1, 5'd1));
      chk("t3_next_flows", opd0, OP_SUB);
      step(1'b0, 32'd0);
      chk("t3_no_r7", rwd0 == 5'd7, 0);
      step(1'b0, 32'd0);

      // r0 is never forwarded
      step(1'b1, mk(OP_ADD, 5'd0, 5'd1, 5'd1));
      step(1'b1, mk(OP_ADD, 5'd2, 5'd0, 5'd0));
      chk("t4_sel_a", sa0, 0);
      chk("t4_sel_b", sb0, 0);

      // three writers of r9: youngest wins; then a 4-deep gap
      repeat (3) step(1'b1, mk(OP_ADD, 5'd9, 5'd1, 5'd1));
      step(1'b1, mk(OP_ADD, 5'd11, 5'd9, 5'd9));
      chk("t5_sel_d3", sa0, 1);
      chk("t5_sel_d5", sa1, 1);
      step(1'b1, mk(OP_ADD, 5'd9, 5'd1, 5'd1));
      repeat (3) step(1'b1, mk(OP_ADD, 5'd10, 5'd1, 5'd1));
      step(1'b1, mk(OP_ADD, 5'd11, 5'd9, 5'd9));
      chk("t5_gap_d5", sa1, 4);
      chk("t5_gap_d3", sa0, 0);

      // reset in the middle of a load-use stall
      step(1'b1, mk(OP_LD, 5'd5, 5'd1, 5'd0));
      step(1'b1, mk(OP_SUB, 5'd6, 5'd5, 5'd1));
      chk("t6_stall_pre", st0, 1);
      #1;
      reset = 1'b1;
      #1;
      chk_zero("t6_in_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_zero("t6_after_release");
      @(posedge clk);
      model_edge(1'b1, ins);
      #1;
      chk("t6_stall_post", st0, 0);
      chk("t6_sel_a", sa0, 0);
      chk("t6_op_dec", opd0, OP_SUB);

      // random traffic on a small register set to provoke hazards
      rv = 1'b0;
      ri = '0;
      for (int n = 0; n < 400; n++) begin
         if (!last_stall) begin
            rv = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 7))
               0:       rop = OP_ADD;
               1:       rop = OP_ADDI;
               2, 3:    rop = OP_LD;
               4:       rop = OP_ST;
               5:       rop = OP_JMP;
               6:       rop = OP_JC;
               default: rop = 6'($urandom_range(32, 63));
            endcase
            ri = {rop, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 11'($urandom_range(0, 2047))};
         end
         step(rv, ri);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
